// File: rtl/autosym_sweep_ctrl_if.sv
// Host/FUT-facing bundle of the autosymmetry sweep sequencer; master = host plus FUT model,
// slave = sequencer. fut_y must be combinational from fut_vec within the same cycle.
interface autosym_sweep_ctrl_if #(
    parameter int N     = 15,
    parameter int CNT_W = N + 1
);
    logic             start;
    logic [N-1:0]     alpha;
    logic             abort;
    logic [N-1:0]     fut_vec;
    logic             fut_y;
    logic             busy;
    logic             done;
    logic             is_sym;
    logic [N-1:0]     fail_vec;
    logic [CNT_W-1:0] onset_cnt;

    modport master (
        output start, alpha, abort, fut_y,
        input  fut_vec, busy, done, is_sym, fail_vec, onset_cnt
    );

    modport slave (
        input  start, alpha, abort, fut_y,
        output fut_vec, busy, done, is_sym, fail_vec, onset_cnt
    );
endinterface

// File: rtl/autosym_sweep_ctrl.sv
// Sweeps every x, evaluating f(x) then f(x^alpha) on one shared FUT, to decide whether alpha is an autosymmetry of f.
// Full sweep takes 2*2^N cycles; done follows 2*2^N+1 cycles after start, earlier on the first mismatch.
module autosym_sweep_ctrl #(
    parameter int N     = 15,
    parameter int CNT_W = N + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    autosym_sweep_ctrl_if.slave  sw
);

    typedef enum logic [1:0] {IDLE, EVAL_A, EVAL_B, FIN} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     x_q, x_d;
    logic [N-1:0]     alpha_q, alpha_d;
    logic             fa_q, fa_d;
    logic [CNT_W-1:0] onset_cnt_q, onset_cnt_d;
    logic [N-1:0]     fail_vec_q, fail_vec_d;
    logic             is_sym_q, is_sym_d;

    logic mismatch;
    logic last_x;

    assign mismatch = (sw.fut_y != fa_q);
    assign last_x   = (x_q == {N{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            alpha_q     <= '0;
            fa_q        <= 1'b0;
            onset_cnt_q <= '0;
            fail_vec_q  <= '0;
            is_sym_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            alpha_q     <= alpha_d;
            fa_q        <= fa_d;
            onset_cnt_q <= onset_cnt_d;
            fail_vec_q  <= fail_vec_d;
            is_sym_q    <= is_sym_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        alpha_d     = alpha_q;
        fa_d        = fa_q;
        onset_cnt_d = onset_cnt_q;
        fail_vec_d  = fail_vec_q;
        is_sym_d    = is_sym_q;
        // Abort freezes every result register so the partial sweep stays observable.
        if (sw.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sw.start) begin
                        state_d     = EVAL_A;
                        alpha_d     = sw.alpha;
                        x_d         = '0;
                        onset_cnt_d = '0;
                        fail_vec_d  = '0;
                        is_sym_d    = 1'b0;
                    end
                end
                EVAL_A: begin
                    state_d = EVAL_B;
                    fa_d    = sw.fut_y;
                    if (sw.fut_y) begin
                        onset_cnt_d = onset_cnt_q + CNT_W'(1);
                    end
                end
                EVAL_B: begin
                    if (mismatch) begin
                        state_d    = FIN;
                        fail_vec_d = x_q;
                        is_sym_d   = 1'b0;
                    end else if (last_x) begin
                        state_d  = FIN;
                        is_sym_d = 1'b1;
                    end else begin
                        state_d = EVAL_A;
                        x_d     = x_q + N'(1);
                    end
                end
                FIN: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sw.fut_vec   = '0;
        sw.busy      = 1'b0;
        sw.done      = 1'b0;
        sw.is_sym    = is_sym_q;
        sw.fail_vec  = fail_vec_q;
        sw.onset_cnt = onset_cnt_q;
        unique case (state_q)
            EVAL_A: begin
                sw.fut_vec = x_q;
                sw.busy    = 1'b1;
            end
            EVAL_B: begin
                sw.fut_vec = x_q ^ alpha_q;
                sw.busy    = 1'b1;
            end
            FIN:     sw.done = !sw.abort;
            default: sw.fut_vec = '0;
        endcase
    end

endmodule

// File: tb/tb_autosym_sweep_ctrl.sv
// Randomized bench for autosym_sweep_ctrl: the FUT is a truth table, and expected results come
// from a direct search for the first x with f(x) != f(x^alpha).
module tb_autosym_sweep_ctrl;

    localparam int N     = 10;
    localparam int CNT_W = N + 1;
    localparam int NV    = 1 << N;
    localparam int LIMIT = 2 * NV + 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    autosym_sweep_ctrl_if #(.N(N), .CNT_W(CNT_W)) sw ();
    autosym_sweep_ctrl #(.N(N), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .sw(sw));

    logic tt [NV];
    always_comb sw.fut_y = tt[sw.fut_vec];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: x0&x1, mode 1: constant 1, mode 2: random f with f(x)==f(x^s) by construction
    task automatic fill(input int mode, input logic [N-1:0] s);
        for (int x = 0; x < NV; x++) begin
            case (mode)
                0:       tt[x] = ((x & 3) == 3);
                1:       tt[x] = 1'b1;
                default: tt[x] = ((x ^ int'(s)) < x) ? tt[x ^ int'(s)] : 1'($urandom);
            endcase
        end
    endtask

    task automatic model(input logic [N-1:0] a, output bit sym, output int fail,
                         output int onset, output int cyc);
        sym   = 1'b1;
        fail  = 0;
        onset = 0;
        cyc   = 2 * NV + 1;
        for (int x = 0; x < NV; x++) begin
            if (tt[x]) onset++;
            if (tt[x] != tt[x ^ int'(a)]) begin
                sym  = 1'b0;
                fail = x;
                cyc  = 2 * (x + 1) + 1;
                return;
            end
        end
    endtask

    function automatic int onset_before(input int c);
        int s = 0;
        for (int x = 0; (2 * x + 1 < c) && (x < NV); x++) if (tt[x]) s++;
        return s;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ":busy"},   32'(sw.busy),      0);
        check({tag, ":done"},   32'(sw.done),      0);
        check({tag, ":is_sym"}, 32'(sw.is_sym),    0);
        check({tag, ":fail"},   32'(sw.fail_vec),  0);
        check({tag, ":onset"},  32'(sw.onset_cnt), 0);
        check({tag, ":fut"},    32'(sw.fut_vec),   0);
    endtask

    // Cycle 1 is the first EVAL_A cycle; restart/abort/rst are driven during the given cycle.
    task automatic run_sweep(input string tag, input logic [N-1:0] a,
                             input int restart_at, input int abort_at, input int rst_at);
        bit e_sym;
        int e_fail, e_onset, e_cyc, cyc, x, ev;
        bit ended;
        model(a, e_sym, e_fail, e_onset, e_cyc);
        @(negedge clk);
        sw.start = 1'b1;
        sw.alpha = a;
        @(negedge clk);
        sw.start = 1'b0;
        sw.alpha = N'($urandom);
        cyc   = 1;
        ended = 1'b0;
        while (!ended && cyc < LIMIT) begin
            if (sw.done) begin
                check({tag, ":latency"}, 32'(cyc), 32'(e_cyc));
                check({tag, ":is_sym"},  32'(sw.is_sym), 32'(e_sym));
                check({tag, ":fail"},    32'(sw.fail_vec), 32'(e_fail));
                check({tag, ":onset"},   32'(sw.onset_cnt), 32'(e_onset));
                check({tag, ":fin_busy"}, 32'(sw.busy), 0);
                check({tag, ":fin_fut"}, 32'(sw.fut_vec), 0);
                @(negedge clk);
                check({tag, ":done_1cyc"}, 32'(sw.done), 0);
                check({tag, ":hold_sym"},  32'(sw.is_sym), 32'(e_sym));
                check({tag, ":hold_fail"}, 32'(sw.fail_vec), 32'(e_fail));
                check({tag, ":hold_onset"}, 32'(sw.onset_cnt), 32'(e_onset));
                ended = 1'b1;
            end else begin
                x  = (cyc - 1) / 2;
                ev = (cyc % 2 == 1) ? x : (x ^ int'(a));
                check({tag, ":fut_vec"}, 32'(sw.fut_vec), 32'(ev));
                check({tag, ":busy"}, 32'(sw.busy), 1);
                if (cyc == restart_at) begin
                    sw.start = 1'b1;
                    sw.alpha = ~a;
                end
                if (cyc == abort_at) sw.abort = 1'b1;
                if (cyc == rst_at) rst = 1'b1;
                @(negedge clk);
                sw.start = 1'b0;
                cyc++;
                if (cyc - 1 == abort_at) begin
                    sw.abort = 1'b0;
                    check({tag, ":ab_busy"}, 32'(sw.busy), 0);
                    check({tag, ":ab_fut"},  32'(sw.fut_vec), 0);
                    check({tag, ":ab_sym"},  32'(sw.is_sym), 0);
                    check({tag, ":ab_fail"}, 32'(sw.fail_vec), 0);
                    check({tag, ":ab_onset"}, 32'(sw.onset_cnt), 32'(onset_before(abort_at)));
                    for (int i = 0; i < 4; i++) begin
                        check({tag, ":ab_nodone"}, 32'(sw.done), 0);
                        @(negedge clk);
                    end
                    ended = 1'b1;
                end
                if (cyc - 1 == rst_at) begin
                    rst = 1'b0;
                    check_zero({tag, ":rst"});
                    ended = 1'b1;
                end
            end
        end
        if (!ended) check({tag, ":timeout"}, 0, 1);
    endtask

    initial begin
        logic [N-1:0] s;
        bit e_sym;
        int e_fail, e_onset, e_cyc;
        rst      = 1'b1;
        sw.start = 1'b0;
        sw.abort = 1'b0;
        sw.alpha = '0;
        fill(0, '0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        run_sweep("and_a4", N'(4), -1, -1, -1);
        run_sweep("and_a1", N'(1), -1, -1, -1);
        fill(1, '0);
        run_sweep("one_a0", N'(0), -1, -1, -1);
        fill(0, '0);
        run_sweep("abort100", N'(4), -1, 100, -1);
        run_sweep("rst50", N'(4), -1, -1, 50);
        repeat (10) @(negedge clk);
        run_sweep("after_rst", N'(4), -1, -1, -1);
        run_sweep("restart", N'(4), 20, -1, -1);

        // start and abort together in IDLE must leave the block idle
        @(negedge clk);
        sw.start = 1'b1;
        sw.abort = 1'b1;
        sw.alpha = N'(4);
        @(negedge clk);
        sw.start = 1'b0;
        sw.abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("idle_sa:busy", 32'(sw.busy), 0);
            check("idle_sa:done", 32'(sw.done), 0);
            check("idle_sa:fut",  32'(sw.fut_vec), 0);
            @(negedge clk);
        end

        for (int i = 0; i < 3; i++) begin
            s = N'($urandom);
            fill(2, s);
            run_sweep("rnd_sym", s, -1, -1, -1);
            for (int j = 0; j < 3; j++) run_sweep("rnd_alpha", N'($urandom), -1, -1, -1);
            model(s, e_sym, e_fail, e_onset, e_cyc);
            run_sweep("rnd_abort", s, -1, $urandom_range(2, e_cyc - 1), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
